// File: rtl/shifter_pkg.sv
// Shared definitions for the SPI barrel shifter: opcodes, FSM states
// and the shift/rotate datapath function.
package shifter_pkg;

    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_SAR = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b1001;
    localparam logic [3:0] OP_ROR = 4'b1010;

    localparam int MAXW = 64;

    typedef logic [MAXW-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        RX_OP,
        RX_A,
        RX_B,
        EXECUTE,
        TX
    } state_t;

    function automatic logic op_valid(input logic [3:0] op);
        return op inside {OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR};
    endfunction

    // Operands live in the low w bits of a MAXW container; w is a power of two.
    function automatic word_t shift_op(
        input logic [3:0]  op,
        input word_t       a,
        input word_t       b,
        input logic        sat,
        input int unsigned w
    );
        word_t mask;
        word_t amt;
        word_t fill;
        word_t r;
        logic  big;
        logic  msb;
        mask = (w >= MAXW) ? '1 : ((word_t'(1) << w) - word_t'(1));
        amt  = b & word_t'(w - 1);
        big  = sat && ((b & mask) >= word_t'(w));
        msb  = |(a & (word_t'(1) << (w - 1)));
        fill = msb ? (mask & ~(mask >> amt)) : '0;
        unique case (1'b1)
            (op == OP_SHL): r = big ? '0 : (a << amt);
            (op == OP_SHR): r = big ? '0 : (a >> amt);
            (op == OP_SAR): r = big ? (msb ? mask : '0) : ((a >> amt) | fill);
            (op == OP_ROL): r = (a << amt) |
                ((amt == '0) ? '0 : (a >> (word_t'(w) - amt)));
            (op == OP_ROR): r = (a >> amt) |
                ((amt == '0) ? '0 : (a << (word_t'(w) - amt)));
            default:        r = a;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/spi_bus_if.sv
// SPI bus bundle shared between master and slave peripherals.
interface spi_bus_if;
    logic sclk;
    logic nss;
    logic mosi;
    logic miso;

    modport SLAVE  (input sclk, input nss, input mosi, output miso);
    modport MASTER (output sclk, output nss, output mosi, input miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronisers for the SPI pins and an sclk rising-edge pulse.
module spi_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic nss_i,
    input  logic mosi_i,
    output logic sclk_rise_o,
    output logic nss_o,
    output logic mosi_o
);

    logic [1:0] sclk_q;
    logic [1:0] nss_q;
    logic [1:0] mosi_q;
    logic       sclk_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q      <= '0;
            nss_q       <= '0;
            mosi_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[0], sclk_i};
            nss_q       <= {nss_q[0], nss_i};
            mosi_q      <= {mosi_q[0], mosi_i};
            sclk_prev_q <= sclk_q[1];
        end
    end

    assign sclk_rise_o = sclk_q[1] & ~sclk_prev_q;
    assign nss_o       = nss_q[1];
    assign mosi_o      = mosi_q[1];

endmodule

// File: rtl/spi_barrel_shifter_gen.sv
// SPI-slave shift/rotate unit: receives opcode, A and B, then returns
// the REG_WIDTH result on MISO within the same nss frame.
module spi_barrel_shifter_gen
    import shifter_pkg::*;
#(
    parameter int REG_WIDTH = 32,
    parameter bit SAT_SHIFT = 1'b1
) (
    input  logic      clock,
    input  logic      reset,
    spi_bus_if.SLAVE  spi_if,
    output logic      result_valid,
    output logic      op_error
);

    localparam int SHW = $clog2(REG_WIDTH);
    localparam int CW  = SHW + 1;

    logic rise;
    logic nss_s;
    logic mosi_s;

    spi_sync_edge u_sync (
        .clk_i       (clock),
        .rst_i       (reset),
        .sclk_i      (spi_if.sclk),
        .nss_i       (spi_if.nss),
        .mosi_i      (spi_if.mosi),
        .sclk_rise_o (rise),
        .nss_o       (nss_s),
        .mosi_o      (mosi_s)
    );

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [REG_WIDTH-1:0] sh_q, sh_d;
    logic [3:0]           op_q, op_d;
    logic [REG_WIDTH-1:0] a_q, a_d;
    logic [REG_WIDTH-1:0] b_q, b_d;
    logic [REG_WIDTH-1:0] tx_q, tx_d;
    logic                 armed_q, armed_d;
    logic                 rv_q, rv_d;
    logic                 err_q, err_d;

    logic [REG_WIDTH-1:0] rx_word;
    logic                 last_op;
    logic                 last_w;
    word_t                res_w;

    assign rx_word = {sh_q[REG_WIDTH-2:0], mosi_s};
    assign last_op = (cnt_q == CW'(3));
    assign last_w  = (cnt_q == CW'(REG_WIDTH - 1));
    assign res_w   = shift_op(op_q, word_t'(a_q), word_t'(b_q),
                              SAT_SHIFT, REG_WIDTH);

    if (REG_WIDTH < MAXW) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^res_w[MAXW-1:REG_WIDTH];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        tx_d    = tx_q;
        armed_d = armed_q;
        rv_d    = 1'b0;
        err_d   = err_q;
        // A frame may only start after nss has been seen high.
        if (nss_s) begin
            armed_d = 1'b1;
        end
        if (state_q != IDLE && nss_s) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!nss_s && armed_q) begin
                        state_d = RX_OP;
                        cnt_d   = '0;
                        sh_d    = '0;
                        armed_d = 1'b0;
                    end
                end
                RX_OP: begin
                    if (rise) begin
                        if (last_op) begin
                            op_d    = rx_word[3:0];
                            sh_d    = '0;
                            cnt_d   = '0;
                            state_d = RX_A;
                        end else begin
                            sh_d  = rx_word;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                RX_A: begin
                    if (rise) begin
                        if (last_w) begin
                            a_d     = rx_word;
                            sh_d    = '0;
                            cnt_d   = '0;
                            state_d = RX_B;
                        end else begin
                            sh_d  = rx_word;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                RX_B: begin
                    if (rise) begin
                        if (last_w) begin
                            b_d     = rx_word;
                            sh_d    = '0;
                            cnt_d   = '0;
                            state_d = EXECUTE;
                        end else begin
                            sh_d  = rx_word;
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                EXECUTE: begin
                    tx_d    = res_w[REG_WIDTH-1:0];
                    rv_d    = 1'b1;
                    err_d   = !op_valid(op_q);
                    cnt_d   = '0;
                    state_d = TX;
                end
                TX: begin
                    if (rise) begin
                        tx_d = {tx_q[REG_WIDTH-2:0], 1'b0};
                        if (last_w) begin
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            tx_q    <= '0;
            armed_q <= 1'b0;
            rv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
            armed_q <= armed_d;
            rv_q    <= rv_d;
            err_q   <= err_d;
        end
    end

    assign spi_if.miso  = (state_q == TX) ? tx_q[REG_WIDTH-1] : 1'b0;
    assign result_valid = rv_q;
    assign op_error     = err_q;

endmodule

// File: tb/tb_spi_barrel_shifter_gen.sv
// Bench for spi_barrel_shifter_gen: SAT_SHIFT=1 and SAT_SHIFT=0 instances
// share one SPI master; vector table, random frames and corner sequences.
module tb_spi_barrel_shifter_gen;

    logic clock = 1'b0;
    logic reset;
    logic sclk, nss, mosi;
    logic rv1, rv0, err1, err0;

    spi_bus_if bus1 ();
    spi_bus_if bus0 ();

    assign bus1.sclk = sclk;
    assign bus1.nss  = nss;
    assign bus1.mosi = mosi;
    assign bus0.sclk = sclk;
    assign bus0.nss  = nss;
    assign bus0.mosi = mosi;

    spi_barrel_shifter_gen #(.REG_WIDTH(32), .SAT_SHIFT(1'b1)) dut1 (
        .clock        (clock),
        .reset        (reset),
        .spi_if       (bus1.SLAVE),
        .result_valid (rv1),
        .op_error     (err1)
    );

    spi_barrel_shifter_gen #(.REG_WIDTH(32), .SAT_SHIFT(1'b0)) dut0 (
        .clock        (clock),
        .reset        (reset),
        .spi_if       (bus0.SLAVE),
        .result_valid (rv0),
        .op_error     (err0)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int rvc1  = 0;
    int rvc0  = 0;

    always @(negedge clock) begin
        if (rv1) rvc1++;
        if (rv0) rvc0++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit expired, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e1;
        logic [31:0] e0;
        logic        err;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Behavioural reference: plain shift/rotate arithmetic on 32 bits.
    function automatic logic [31:0] ref_model(input logic [3:0] op,
        input logic [31:0] a, input logic [31:0] b, input bit sat);
        int          n    = int'(b % 32);
        bit          over = sat && (b >= 32);
        logic [63:0] dbl  = {a, a};
        case (op)
            4'h6: return over ? 32'h0 : (a << n);
            4'h7: return over ? 32'h0 : (a >> n);
            4'h8: return over ? 32'($signed(a) >>> 31)
                              : 32'($signed(a) >>> n);
            4'h9: begin
                dbl = dbl << n;
                return dbl[63:32];
            end
            4'hA: begin
                dbl = dbl >> n;
                return dbl[31:0];
            end
            default: return a;
        endcase
    endfunction

    // abort_at: input-bit index where nss rises together with sclk (-1: none).
    task automatic frame(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int abort_at,
                         input int tx_bits,
                         output logic [31:0] r1, output logic [31:0] r0);
        logic [67:0] bits;
        bits = {op, a, b};
        r1   = '0;
        r0   = '0;
        nss  = 1'b0;
        wait_n(5);
        for (int i = 0; i < 68; i++) begin
            mosi = bits[67-i];
            wait_n(5);
            if (i == abort_at) begin
                nss  = 1'b1;
                sclk = 1'b1;
                wait_n(5);
                sclk = 1'b0;
                return;
            end
            sclk = 1'b1;
            wait_n(5);
            sclk = 1'b0;
        end
        for (int i = 0; i < tx_bits; i++) begin
            wait_n(5);
            r1[31-i] = bus1.miso;
            r0[31-i] = bus0.miso;
            sclk = 1'b1;
            wait_n(5);
            sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        wait_n(5);
        nss = 1'b1;
        wait_n(5);
    endtask

    task automatic run_full(input string tag, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e1, input logic [31:0] e0,
                            input logic eerr);
        logic [31:0] r1, r0;
        int s1, s0;
        s1 = rvc1;
        s0 = rvc0;
        frame(op, a, b, -1, 32, r1, r0);
        end_frame();
        chk({tag, " miso sat1"}, r1, e1);
        chk({tag, " miso sat0"}, r0, e0);
        chk({tag, " rv count sat1"}, 32'(rvc1 - s1), 32'd1);
        chk({tag, " rv count sat0"}, 32'(rvc0 - s0), 32'd1);
        chk({tag, " op_error"}, {31'b0, err1}, {31'b0, eerr});
        chk({tag, " op_error sat0"}, {31'b0, err0}, {31'b0, eerr});
        chk({tag, " miso idle"}, {31'b0, bus1.miso}, 32'd0);
    endtask

    initial begin
        logic [31:0] r1, r0, a, b;
        logic [3:0]  op;
        int          s1;

        tbl[0]  = '{4'h6, 32'h000000F0, 32'd4,  32'h00000F00, 32'h00000F00, 1'b0};
        tbl[1]  = '{4'h8, 32'h80000000, 32'd31, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
        tbl[2]  = '{4'h7, 32'h80000000, 32'd31, 32'h00000001, 32'h00000001, 1'b0};
        tbl[3]  = '{4'hA, 32'h00000001, 32'd1,  32'h80000000, 32'h80000000, 1'b0};
        tbl[4]  = '{4'h9, 32'h80000001, 32'd36, 32'h00000018, 32'h00000018, 1'b0};
        tbl[5]  = '{4'h6, 32'h00000001, 32'd40, 32'h00000000, 32'h00000100, 1'b0};
        tbl[6]  = '{4'hF, 32'h12345678, 32'd5,  32'h12345678, 32'h12345678, 1'b1};
        tbl[7]  = '{4'h6, 32'h00000001, 32'd1,  32'h00000002, 32'h00000002, 1'b0};
        tbl[8]  = '{4'h8, 32'h80000000, 32'd40, 32'hFFFFFFFF, 32'hFF800000, 1'b0};
        tbl[9]  = '{4'hA, 32'h12345678, 32'd32, 32'h12345678, 32'h12345678, 1'b0};
        tbl[10] = '{4'h6, 32'hFFFFFFFF, 32'd32, 32'h00000000, 32'hFFFFFFFF, 1'b0};
        tbl[11] = '{4'h8, 32'h40000000, 32'd31, 32'h00000000, 32'h00000000, 1'b0};

        reset = 1'b1;
        nss   = 1'b1;
        sclk  = 1'b0;
        mosi  = 1'b0;
        wait_n(3);
        chk("reset miso", {31'b0, bus1.miso}, 32'd0);
        chk("reset result_valid", {31'b0, rv1}, 32'd0);
        chk("reset op_error", {31'b0, err1}, 32'd0);
        reset = 1'b0;
        wait_n(5);

        for (int i = 0; i < 12; i++) begin
            run_full($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                     tbl[i].e1, tbl[i].e0, tbl[i].err);
        end

        for (int i = 0; i < 24; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(6, 10));
            a = $urandom;
            case ($urandom_range(0, 2))
                0:       b = 32'($urandom_range(0, 31));
                1:       b = 32'($urandom_range(32, 70));
                default: b = $urandom;
            endcase
            run_full($sformatf("rand%0d", i), op, a, b,
                     ref_model(op, a, b, 1'b1), ref_model(op, a, b, 1'b0),
                     !(op inside {[4'h6:4'hA]}));
        end

        // Abort mid-A with an sclk rise on the same edge as nss.
        run_full("bad op", 4'hF, 32'hCAFEF00D, 32'd3,
                 32'hCAFEF00D, 32'hCAFEF00D, 1'b1);
        s1 = rvc1;
        frame(4'h7, 32'hFFFFFFFF, 32'd1, 24, 0, r1, r0);
        wait_n(10);
        chk("abort rv count", 32'(rvc1 - s1), 32'd0);
        chk("abort op_error held", {31'b0, err1}, 32'd1);
        chk("abort miso", {31'b0, bus1.miso}, 32'd0);
        run_full("after abort", 4'h7, 32'h000000F0, 32'd4,
                 32'h0000000F, 32'h0000000F, 1'b0);

        // nss held low after TX must not restart the frame.
        s1 = rvc1;
        frame(4'h6, 32'h00000003, 32'd2, -1, 32, r1, r0);
        chk("held frame miso", r1, 32'h0000000C);
        for (int i = 0; i < 68; i++) begin
            mosi = 1'($urandom_range(0, 1));
            wait_n(5);
            sclk = 1'b1;
            wait_n(5);
            sclk = 1'b0;
        end
        wait_n(10);
        chk("held low rv count", 32'(rvc1 - s1), 32'd1);
        chk("held low miso", {31'b0, bus1.miso}, 32'd0);
        end_frame();

        // Reset in the middle of TX.
        frame(4'h0, 32'hFFFFFFFF, 32'd0, -1, 10, r1, r0);
        chk("pre-reset tx bits", r1, 32'hFFC00000);
        chk("pre-reset miso", {31'b0, bus1.miso}, 32'd1);
        chk("pre-reset op_error", {31'b0, err1}, 32'd1);
        reset = 1'b1;
        wait_n(1);
        chk("tx reset miso", {31'b0, bus1.miso}, 32'd0);
        chk("tx reset op_error", {31'b0, err1}, 32'd0);
        chk("tx reset rv", {31'b0, rv1}, 32'd0);
        wait_n(2);
        reset = 1'b0;
        nss   = 1'b1;
        wait_n(5);
        run_full("after reset", 4'h9, 32'h0000000F, 32'd28,
                 32'hF0000000, 32'hF0000000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
